// File: rtl/adder_421_sched.sv
// Round-robin scheduler that feeds a pipelined 4-operand adder and returns tagged sums through a
// credit-protected response FIFO. Define ADDER_421_SCHED_TAG_CHECK_EN to enable the sticky err check.
module adder_421_sched #(
  parameter int IN_WIDTH   = 1024,
  parameter int NREQ       = 4,
  parameter int PIPE_LAT   = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic [NREQ-1:0]              req_valid,
  output logic [NREQ-1:0]              req_ready,
  input  logic [NREQ*4*IN_WIDTH-1:0]   req_ops,
  output logic                         add_in_valid,
  output logic [IN_WIDTH-1:0]          add_A,
  output logic [IN_WIDTH-1:0]          add_B,
  output logic [IN_WIDTH-1:0]          add_C,
  output logic [IN_WIDTH-1:0]          add_D,
  input  logic [IN_WIDTH-1:0]          add_S,
  input  logic                         add_out_valid,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [$clog2(NREQ)-1:0]      rsp_id,
  output logic [IN_WIDTH-1:0]          rsp_data,
  output logic                         err
);
  localparam int IDW = $clog2(NREQ);
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int CW  = $clog2(FIFO_DEPTH + 1);

  logic [IN_WIDTH-1:0] op_a [NREQ];
  logic [IN_WIDTH-1:0] op_b [NREQ];
  logic [IN_WIDTH-1:0] op_c [NREQ];
  logic [IN_WIDTH-1:0] op_d [NREQ];

  // Each requester slice is {A,B,C,D} with A in the most significant quarter.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_ops
    assign op_a[gi] = req_ops[gi*4*IN_WIDTH + 3*IN_WIDTH +: IN_WIDTH];
    assign op_b[gi] = req_ops[gi*4*IN_WIDTH + 2*IN_WIDTH +: IN_WIDTH];
    assign op_c[gi] = req_ops[gi*4*IN_WIDTH + 1*IN_WIDTH +: IN_WIDTH];
    assign op_d[gi] = req_ops[gi*4*IN_WIDTH +: IN_WIDTH];
  end

  logic [IDW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]       credit_q, credit_d;
  logic                add_in_valid_q, add_in_valid_d;
  logic [IDW-1:0]      issue_id_q, issue_id_d;
  logic [IN_WIDTH-1:0] add_a_q, add_a_d, add_b_q, add_b_d;
  logic [IN_WIDTH-1:0] add_c_q, add_c_d, add_d_q, add_d_d;
  logic [PIPE_LAT-1:0] tag_vld_q, tag_vld_d;
  logic [IDW-1:0]      tag_id_q [PIPE_LAT];
  logic [IDW-1:0]      tag_id_d [PIPE_LAT];
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       count_q, count_d;
  logic [IN_WIDTH-1:0] fifo_data_mem [FIFO_DEPTH];
  logic [IDW-1:0]      fifo_id_mem [FIFO_DEPTH];

  logic            accept;
  logic [IDW-1:0]  grant_id;
  logic [IDW:0]    idx;
  logic            push, pop;
  logic            tag_out_vld;
  logic [IDW-1:0]  tag_out_id;

  // Rotating search from rr_ptr; idx carries one spare bit so the wrap compare cannot overflow.
  always_comb begin
    accept   = 1'b0;
    grant_id = '0;
    idx      = '0;
    if (credit_q != '0) begin
      for (int k = 0; k < NREQ; k++) begin
        idx = (IDW+1)'(rr_ptr_q) + (IDW+1)'(k);
        if (idx >= (IDW+1)'(NREQ)) idx = idx - (IDW+1)'(NREQ);
        if (!accept && req_valid[idx[IDW-1:0]]) begin
          accept   = 1'b1;
          grant_id = idx[IDW-1:0];
        end
      end
    end
  end

  assign req_ready = (resetn && accept) ? (NREQ'(1) << grant_id) : '0;

  assign tag_out_vld = tag_vld_q[PIPE_LAT-1];
  assign tag_out_id  = tag_id_q[PIPE_LAT-1];
  assign pop         = (count_q != '0) && rsp_ready;

`ifdef ADDER_421_SCHED_TAG_CHECK_EN
  logic err_q, err_d;
  assign push  = add_out_valid && tag_out_vld;
  assign err_d = err_q | (add_out_valid ^ tag_out_vld);
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) err_q <= 1'b0;
    else         err_q <= err_d;
  end
  assign err = err_q;
`else
  logic unused_add_out_valid;
  assign unused_add_out_valid = add_out_valid;
  assign push = tag_out_vld;
  assign err  = 1'b0;
`endif

  always_comb begin
    rr_ptr_d       = rr_ptr_q;
    if (accept) rr_ptr_d = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + 1'b1;
    credit_d       = credit_q - CW'(accept) + CW'(pop);
    add_in_valid_d = accept;
    issue_id_d     = accept ? grant_id       : issue_id_q;
    add_a_d        = accept ? op_a[grant_id] : add_a_q;
    add_b_d        = accept ? op_b[grant_id] : add_b_q;
    add_c_d        = accept ? op_c[grant_id] : add_c_q;
    add_d_d        = accept ? op_d[grant_id] : add_d_q;
    // The tag enters together with add_in_valid so its last stage lines up with add_out_valid.
    tag_vld_d[0]   = add_in_valid_q;
    tag_id_d[0]    = issue_id_q;
    for (int k = 1; k < PIPE_LAT; k++) begin
      tag_vld_d[k] = tag_vld_q[k-1];
      tag_id_d[k]  = tag_id_q[k-1];
    end
    wr_ptr_d       = wr_ptr_q + PW'(push);
    rd_ptr_d       = rd_ptr_q + PW'(pop);
    count_d        = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rr_ptr_q       <= '0;
      credit_q       <= CW'(FIFO_DEPTH);
      add_in_valid_q <= 1'b0;
      issue_id_q     <= '0;
      add_a_q        <= '0;
      add_b_q        <= '0;
      add_c_q        <= '0;
      add_d_q        <= '0;
      tag_vld_q      <= '0;
      for (int k = 0; k < PIPE_LAT; k++) tag_id_q[k] <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
    end else begin
      rr_ptr_q       <= rr_ptr_d;
      credit_q       <= credit_d;
      add_in_valid_q <= add_in_valid_d;
      issue_id_q     <= issue_id_d;
      add_a_q        <= add_a_d;
      add_b_q        <= add_b_d;
      add_c_q        <= add_c_d;
      add_d_q        <= add_d_d;
      tag_vld_q      <= tag_vld_d;
      tag_id_q       <= tag_id_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
    end
  end

  // Payload storage needs no reset: count_q alone decides whether an entry is meaningful.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data_mem[wr_ptr_q] <= add_S;
      fifo_id_mem[wr_ptr_q]   <= tag_out_id;
    end
  end

  assign add_in_valid = add_in_valid_q;
  assign add_A        = add_a_q;
  assign add_B        = add_b_q;
  assign add_C        = add_c_q;
  assign add_D        = add_d_q;
  assign rsp_valid    = (count_q != '0);
  assign rsp_id       = rsp_valid ? fifo_id_mem[rd_ptr_q]   : '0;
  assign rsp_data     = rsp_valid ? fifo_data_mem[rd_ptr_q] : '0;

endmodule
